// File: rtl/dac_raw_sample_saver.sv
// dac_raw_sample_saver
// Trigger-armed snapshot tap on the raw 16-bit DAC sample stream. A rising
// edge of i_trigger starts a one-shot capture of i_dac_sample_save valid
// samples, which are forwarded onto a 32-bit AXI-Stream master.
// Optional build macro: DAC_RAW_SAVE_PACK_EN (pack two samples per word).
module dac_raw_sample_saver (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        i_trigger,
    input  logic [23:0] i_dac_sample_save
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic        r_trig_d;
    logic        r_armed;
    logic [23:0] r_n;
    logic [23:0] r_count;
    logic [31:0] r_tdata;
    logic        r_tvalid;

    logic [23:0] w_n_nx;
    logic [23:0] w_count_nx;
    logic [31:0] w_tdata_nx;
    logic        w_tvalid_nx;

`ifdef DAC_RAW_SAVE_PACK_EN
    logic [15:0] r_half;
    logic        r_half_vld;
    logic [15:0] w_half_nx;
    logic        w_half_vld_nx;
`endif

    logic        w_rise;
    logic        w_start;
    logic        w_accept;
    logic        w_last;

    // r_armed only becomes set once the trigger has been seen low after
    // reset, so a trigger held high through reset cannot start a capture.
    assign w_rise   = i_trigger & ~r_trig_d & r_armed;
    assign w_start  = (r_state == ST_IDLE) && w_rise && (i_dac_sample_save != '0);
    assign w_accept = (r_state == ST_CAPTURE) && s_axis_tvalid;
    assign w_last   = w_accept && ((r_count + 24'd1) == r_n);

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic: start on a qualified edge, finish on the Nth sample
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:    if (w_start) w_state_nx = ST_CAPTURE;
            ST_CAPTURE: if (w_last)  w_state_nx = ST_IDLE;
            default:    w_state_nx = ST_IDLE;
        endcase
    end

    // Output / datapath next values: count, latched N, pending half, word
    always_comb begin
        w_n_nx      = r_n;
        w_count_nx  = r_count;
        w_tdata_nx  = r_tdata;
        w_tvalid_nx = 1'b0;
`ifdef DAC_RAW_SAVE_PACK_EN
        w_half_nx     = r_half;
        w_half_vld_nx = r_half_vld;
`endif
        if (w_start) begin
            w_n_nx     = i_dac_sample_save;
            w_count_nx = '0;
`ifdef DAC_RAW_SAVE_PACK_EN
            w_half_vld_nx = 1'b0;
`endif
        end
        if (w_accept) begin
            w_count_nx = r_count + 24'd1;
`ifdef DAC_RAW_SAVE_PACK_EN
            if (r_half_vld) begin
                w_tvalid_nx   = 1'b1;
                w_tdata_nx    = {s_axis_tdata, r_half};
                w_half_vld_nx = 1'b0;
            end else if (w_last) begin
                w_tvalid_nx = 1'b1;
                w_tdata_nx  = {16'h0000, s_axis_tdata};
            end else begin
                w_half_nx     = s_axis_tdata;
                w_half_vld_nx = 1'b1;
            end
`else
            w_tvalid_nx = 1'b1;
            w_tdata_nx  = {16'h0000, s_axis_tdata};
`endif
        end
    end

    // Datapath registers, trigger edge history and registered outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_trig_d <= 1'b0;
            r_armed  <= 1'b0;
            r_n      <= '0;
            r_count  <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
`ifdef DAC_RAW_SAVE_PACK_EN
            r_half     <= '0;
            r_half_vld <= 1'b0;
`endif
        end else begin
            r_trig_d <= i_trigger;
            r_armed  <= r_armed | ~i_trigger;
            r_n      <= w_n_nx;
            r_count  <= w_count_nx;
            r_tdata  <= w_tdata_nx;
            r_tvalid <= w_tvalid_nx;
`ifdef DAC_RAW_SAVE_PACK_EN
            r_half     <= w_half_nx;
            r_half_vld <= w_half_vld_nx;
`endif
        end
    end

endmodule

// File: tb/tb_dac_raw_sample_saver.sv
// Directed bench for dac_raw_sample_saver; expectations follow the build
// macro DAC_RAW_SAVE_PACK_EN (packed) or its absence (unpacked).
module tb_dac_raw_sample_saver;

`ifdef DAC_RAW_SAVE_PACK_EN
    localparam bit PACK = 1'b1;
`else
    localparam bit PACK = 1'b0;
`endif

    logic        aclk;
    logic        aresetn;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        i_trigger;
    logic [23:0] i_dac_sample_save;

    int unsigned checks;
    int unsigned failures;
    logic [31:0] last_word;

    dac_raw_sample_saver u_dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .i_trigger         (i_trigger),
        .i_dac_sample_save (i_dac_sample_save)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input, then check the registered outputs after the edge.
    // When no word is expected, tdata must hold the previous word.
    task automatic tick(input logic v, input logic [15:0] d,
                        input logic ev, input logic [31:0] ed, input string tag);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        @(posedge aclk);
        #1;
        check({tag, "_vld"}, {31'd0, m_axis_tvalid}, {31'd0, ev});
        if (ev) last_word = ed;
        check({tag, "_dat"}, m_axis_tdata, last_word);
    endtask

    task automatic idle(input int unsigned cycles, input string tag);
        for (int unsigned i = 0; i < cycles; i++) tick(1'b0, 16'h0000, 1'b0, 32'h0, tag);
    endtask

    // Back-to-back samples base+1 .. base+cnt into a capture of n samples.
    task automatic burst(input int unsigned base, input int unsigned cnt,
                         input int unsigned n, input string tag);
        logic [15:0] k;
        logic        ev;
        logic [31:0] ed;
        for (int unsigned j = 1; j <= cnt; j++) begin
            k = 16'(base + j);
            if (PACK) begin
                ev = (j <= n) && ((j % 2 == 0) || (j == n));
                ed = (j % 2 == 0) ? {k, k - 16'd1} : {16'h0000, k};
            end else begin
                ev = (j <= n);
                ed = {16'h0000, k};
            end
            tick(1'b1, k, ev, ed, tag);
        end
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        last_word         = 32'h0;
        aresetn           = 1'b0;
        s_axis_tdata      = 16'h0;
        s_axis_tvalid     = 1'b0;
        i_trigger         = 1'b0;
        i_dac_sample_save = 24'd0;

        // Reset values
        idle(3, "rst");
        aresetn = 1'b1;
        idle(2, "post_rst");

        // N=8, trigger held high through and after the capture
        i_dac_sample_save = 24'd8;
        i_trigger = 1'b1;
        idle(10, "a_wait");
        burst(0, 20, 8, "a");
        idle(3, "a_tail");

        // Second capture after trigger low for 10 cycles; N changed after latch
        i_trigger = 1'b0;
        idle(10, "b_low");
        i_trigger = 1'b1;
        idle(1, "b_arm");
        i_dac_sample_save = 24'd2;
        burst(20, 20, 8, "b");
        idle(2, "b_tail");

        // N=3 with gapped valid; trigger dropped mid-capture
        i_trigger = 1'b0;
        idle(1, "c_low");
        i_dac_sample_save = 24'd3;
        i_trigger = 1'b1;
        idle(1, "c_arm");
        tick(1'b1, 16'd1, !PACK, 32'h0000_0001, "c_s1");
        i_trigger = 1'b0;
        tick(1'b0, 16'd0, 1'b0, 32'h0, "c_g1");
        tick(1'b1, 16'd2, 1'b1, PACK ? 32'h0002_0001 : 32'h0000_0002, "c_s2");
        tick(1'b0, 16'd0, 1'b0, 32'h0, "c_g2");
        tick(1'b1, 16'd3, 1'b1, 32'h0000_0003, "c_s3");
        tick(1'b0, 16'd0, 1'b0, 32'h0, "c_g3");
        tick(1'b1, 16'd4, 1'b0, 32'h0, "c_s4");
        tick(1'b1, 16'd5, 1'b0, 32'h0, "c_s5");

        // N=0 rising edge: no capture
        i_trigger = 1'b0;
        idle(1, "d_low");
        i_dac_sample_save = 24'd0;
        i_trigger = 1'b1;
        idle(1, "d_arm");
        tick(1'b1, 16'd7, 1'b0, 32'h0, "d_s1");
        tick(1'b1, 16'd8, 1'b0, 32'h0, "d_s2");
        tick(1'b1, 16'd9, 1'b0, 32'h0, "d_s3");

        // Reset mid-capture after 3 samples
        i_trigger = 1'b0;
        idle(1, "e_low");
        i_dac_sample_save = 24'd8;
        i_trigger = 1'b1;
        idle(1, "e_arm");
        burst(0, 3, 8, "e_pre");
        aresetn   = 1'b0;
        last_word = 32'h0;
        idle(2, "e_rst");
        aresetn = 1'b1;
        // Trigger still high from before reset: must not start a capture
        tick(1'b1, 16'd50, 1'b0, 32'h0, "e_hold1");
        tick(1'b1, 16'd51, 1'b0, 32'h0, "e_hold2");
        i_trigger = 1'b0;
        idle(1, "e_low2");
        i_trigger = 1'b1;
        idle(1, "e_arm2");
        burst(0, 8, 8, "e_post");
        tick(1'b1, 16'd99, 1'b0, 32'h0, "e_after");
        idle(2, "e_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
